// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - load/store op encodings as they arrive on ld_op / st_op
//   - owner_t: who the SRAM read data belongs to in the cycle after a grant
//   - acc_t + access_ok(): alignment / legal-op check for a single access
package mem_arb_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;

  typedef enum logic [1:0] {NONE, IF, LD} owner_t;

  typedef enum logic [1:0] {ACC_IF, ACC_LD, ACC_ST} acc_t;

  // True when the access may go to the SRAM: op code defined for that
  // requester and byte offset aligned to the access size.
  function automatic logic access_ok(input acc_t kind, input logic [2:0] op,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (kind)
      ACC_IF: ok = (off == 2'b00);
      ACC_LD: begin
        case (op)
          OP_LB, OP_LBU: ok = 1'b1;
          OP_LH, OP_LHU: ok = ~off[0];
          OP_LW:         ok = (off == 2'b00);
          default:       ok = 1'b0;
        endcase
      end
      ACC_ST: begin
        case (op)
          OP_SB:   ok = 1'b1;
          OP_SH:   ok = ~off[0];
          OP_SW:   ok = (off == 2'b00);
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the three core-side request ports and the
// SRAM macro port of the arbiter.
//   slave  : arbiter view (takes requests, drives grants/responses/SRAM)
//   master : core + memory view (drives requests and mem_rdata)
//
// Handshake: a requester raises *_req with stable op/addr/data and holds it
// until it sees *_gnt high in the same cycle; the transfer happens in that
// cycle (gnt is combinational). Read responses come back as a one-cycle
// *_rvalid pulse in the next cycle, with *_rdata forced to 0 otherwise.
interface mem_port_arbiter_if #(parameter int ADDR_W = 14);

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              ld_req;
  logic [2:0]        ld_op;
  logic [31:0]       ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;

  logic              st_req;
  logic [2:0]        st_op;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic              st_gnt;

  logic              err_valid;
  logic [31:0]       err_addr;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_op, ld_addr,
           st_req, st_op, st_addr, st_data, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
           st_gnt, err_valid, err_addr,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_op, ld_addr,
           st_req, st_op, st_addr, st_data, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
           st_gnt, err_valid, err_addr,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane handling around the SRAM.
//   Store side: i_st_op/i_st_off/i_st_data -> o_st_be (byte enables) and
//               o_st_wdata (byte/half replicated on every lane).
//   Load side : i_ld_op/i_ld_off/i_rdata -> o_ld_data (selected byte/half,
//               sign- or zero-extended).
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  i_st_op,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_op)
      OP_SB: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      OP_SH: begin
        o_st_be    = 4'b0011 << i_st_off;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
      end
    endcase
  end

  // Bring the addressed byte down to lane 0; an aligned half lands there too.
  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_op)
      OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ld_data = {24'h0, w_byte};
      OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between
// instruction fetch, load and store requesters.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave modport) : fetch/load/store request ports and SRAM port
//   o_dbg_starve_cnt    : current fetch starvation count
//   o_dbg_resp_owner    : owner of the SRAM read data in this cycle
// Priority is load > store > fetch, except that a fetch that has been
// denied STARVE_MAX cycles in a row wins outright.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [3:0]          o_dbg_starve_cnt,
  output owner_t              o_dbg_resp_owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  r_starve_cnt, w_starve_nxt;
  owner_t      r_resp_owner, w_owner_nxt;
  logic [2:0]  r_ld_op;
  logic [1:0]  r_ld_off;
  logic        r_ld_zero;
  logic        r_err_valid;
  logic [31:0] r_err_addr;

  logic        w_force_if;
  logic        w_if_gnt, w_ld_gnt, w_st_gnt, w_any_gnt;
  logic        w_if_ok, w_ld_ok, w_st_ok, w_acc_ok;
  logic [31:0] w_sel_addr;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;
  logic        w_if_rvalid, w_ld_rvalid, w_err_valid;

  assign w_if_ok = access_ok(ACC_IF, 3'b000,     bus.if_addr[1:0]);
  assign w_ld_ok = access_ok(ACC_LD, bus.ld_op,  bus.ld_addr[1:0]);
  assign w_st_ok = access_ok(ACC_ST, bus.st_op,  bus.st_addr[1:0]);

  assign w_force_if = bus.if_req && (r_starve_cnt == STARVE_LIM);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ld_gnt = 1'b0;
    w_st_gnt = 1'b0;
    if (!rst) begin
      if (w_force_if)      w_if_gnt = 1'b1;
      else if (bus.ld_req) w_ld_gnt = 1'b1;
      else if (bus.st_req) w_st_gnt = 1'b1;
      else if (bus.if_req) w_if_gnt = 1'b1;
    end
  end

  assign w_any_gnt = w_if_gnt | w_ld_gnt | w_st_gnt;

  always_comb begin
    w_sel_addr = 32'h0;
    if (w_ld_gnt)      w_sel_addr = bus.ld_addr;
    else if (w_st_gnt) w_sel_addr = bus.st_addr;
    else if (w_if_gnt) w_sel_addr = bus.if_addr;
  end

  // A granted but illegal access is consumed without touching the SRAM.
  assign w_acc_ok = (w_if_gnt & w_if_ok) | (w_ld_gnt & w_ld_ok) | (w_st_gnt & w_st_ok);

  mem_lane_align u_align (
    .i_st_op    (bus.st_op),
    .i_st_off   (bus.st_addr[1:0]),
    .i_st_data  (bus.st_data),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_op    (r_ld_op),
    .i_ld_off   (r_ld_off),
    .i_rdata    (bus.mem_rdata),
    .o_ld_data  (w_ld_data)
  );

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.st_gnt    = w_st_gnt;
  assign bus.mem_en    = w_acc_ok;
  assign bus.mem_we    = w_st_gnt & w_st_ok;
  assign bus.mem_addr  = w_acc_ok ? w_sel_addr[ADDR_W+1:2] : '0;
  assign bus.mem_be    = (w_st_gnt & w_st_ok) ? w_st_be : (w_acc_ok ? 4'b1111 : 4'b0000);
  assign bus.mem_wdata = (w_st_gnt & w_st_ok) ? w_st_wdata : 32'h0;

  // Next-state for the starvation counter and the response owner.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    w_owner_nxt  = NONE;
    if (!bus.if_req || w_if_gnt)       w_starve_nxt = 4'd0;
    else if (r_starve_cnt < STARVE_LIM) w_starve_nxt = r_starve_cnt + 4'd1;
    // A misaligned/illegal load still owes the core a (zero) response;
    // a misaligned fetch only reports the error.
    if (w_if_gnt && w_if_ok) w_owner_nxt = IF;
    else if (w_ld_gnt)       w_owner_nxt = LD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_resp_owner <= NONE;
      r_ld_op      <= 3'b000;
      r_ld_off     <= 2'b00;
      r_ld_zero    <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= 32'h0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_resp_owner <= w_owner_nxt;
      if (w_ld_gnt) begin
        r_ld_op   <= bus.ld_op;
        r_ld_off  <= bus.ld_addr[1:0];
        r_ld_zero <= ~w_ld_ok;
      end
      r_err_valid <= w_any_gnt & ~w_acc_ok;
      r_err_addr  <= (w_any_gnt & ~w_acc_ok) ? w_sel_addr : 32'h0;
    end
  end

  // Response outputs are masked during reset so an in-flight read from the
  // cycle before reset is dropped.
  assign w_if_rvalid   = ~rst & (r_resp_owner == IF);
  assign w_ld_rvalid   = ~rst & (r_resp_owner == LD);
  assign w_err_valid   = ~rst & r_err_valid;

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.ld_rvalid = w_ld_rvalid;
  assign bus.ld_rdata  = (w_ld_rvalid && !r_ld_zero) ? w_ld_data : 32'h0;
  assign bus.err_valid = w_err_valid;
  assign bus.err_addr  = w_err_valid ? r_err_addr : 32'h0;

  assign o_dbg_starve_cnt = r_starve_cnt;
  assign o_dbg_resp_owner = r_resp_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with an SRAM
// model, a transaction-level reference model checked every cycle, and
// hand-computed literal expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int W_NONE = 0, W_IF = 1, W_LD = 2, W_ST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dbg_starve;
  owner_t     dbg_owner;
  int         tests = 0;
  int         fails = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .o_dbg_starve_cnt (dbg_starve),
    .o_dbg_resp_owner (dbg_owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01020304) ^ 32'h00000013;
  endfunction

  // ---------------- SRAM macro model ----------------
  logic [31:0] sram [DEPTH];
  bit          sram_loaded;
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) sram[bus.mem_addr][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
      end else begin
        bus.mem_rdata <= sram[bus.mem_addr];
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  bit          model_loaded;
  logic [31:0] if_exp_q[$];
  logic [31:0] ld_exp_q[$];
  logic [31:0] err_exp_q[$];
  int          m_starve = 0;

  int          m_win, m_size, m_off, m_widx;
  bit          m_ok;
  logic [31:0] m_a, m_d, m_word;
  logic        m_en, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_maddr, m_wd;
  logic        ev_if, ev_ld, ev_err;
  logic [31:0] e_ifd, e_ldd, e_erra;

  function automatic int ld_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic int st_size(input logic [2:0] op);
    case (op)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 0;
    endcase
  endfunction

  // Load result from the whole memory word, by arithmetic on the value.
  function automatic logic [31:0] ld_extract(input logic [2:0] op, input logic [31:0] word,
                                              input int off);
    logic [31:0] v;
    v = word >> (8 * off);
    case (op)
      3'b000:  begin v = v % 256;   return (v >= 128)   ? v + 32'hFFFFFF00 : v; end
      3'b100:  return v % 256;
      3'b001:  begin v = v % 65536; return (v >= 32768) ? v + 32'hFFFF0000 : v; end
      3'b101:  return v % 65536;
      default: return word;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!model_loaded) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
      model_loaded = 1'b1;
    end
    // responses owed from the previous cycle
    ev_if = 0; ev_ld = 0; ev_err = 0; e_ifd = 0; e_ldd = 0; e_erra = 0;
    if (rst) begin
      if_exp_q.delete(); ld_exp_q.delete(); err_exp_q.delete();
    end else begin
      if (if_exp_q.size() != 0)  begin ev_if  = 1; e_ifd  = if_exp_q.pop_front();  end
      if (ld_exp_q.size() != 0)  begin ev_ld  = 1; e_ldd  = ld_exp_q.pop_front();  end
      if (err_exp_q.size() != 0) begin ev_err = 1; e_erra = err_exp_q.pop_front(); end
    end
    // who wins this cycle
    m_win = W_NONE;
    if (!rst) begin
      if (bus.if_req && m_starve == STARVE_MAX) m_win = W_IF;
      else if (bus.ld_req)                      m_win = W_LD;
      else if (bus.st_req)                      m_win = W_ST;
      else if (bus.if_req)                      m_win = W_IF;
    end
    m_en = 0; m_we = 0; m_be = 0; m_maddr = 0; m_wd = 0; m_ok = 0;
    m_a = 0; m_d = 0; m_size = 0;
    case (m_win)
      W_IF: begin m_a = bus.if_addr; m_size = 4; end
      W_LD: begin m_a = bus.ld_addr; m_size = ld_size(bus.ld_op); end
      W_ST: begin m_a = bus.st_addr; m_size = st_size(bus.st_op); m_d = bus.st_data; end
      default: ;
    endcase
    m_off  = int'(m_a % 4);
    m_widx = int'((m_a >> 2) % DEPTH);
    m_ok   = (m_win != W_NONE) && (m_size != 0) && (m_a % m_size == 0);
    if (m_ok) begin
      m_en    = 1;
      m_maddr = 32'(m_widx);
      m_be    = 4'hF;
      if (m_win == W_ST) begin
        m_we = 1;
        m_be = 0;
        for (int k = 0; k < m_size; k++) m_be = m_be + 4'(1 << (m_off + k));
        if (m_size == 1)      m_wd = (m_d % 256) * 32'h01010101;
        else if (m_size == 2) m_wd = (m_d % 65536) * 32'h00010001;
        else                  m_wd = m_d;
      end
    end
    chk("m_if_gnt",    32'(bus.if_gnt),    32'(m_win == W_IF));
    chk("m_ld_gnt",    32'(bus.ld_gnt),    32'(m_win == W_LD));
    chk("m_st_gnt",    32'(bus.st_gnt),    32'(m_win == W_ST));
    chk("m_mem_en",    32'(bus.mem_en),    32'(m_en));
    chk("m_mem_we",    32'(bus.mem_we),    32'(m_we));
    chk("m_mem_be",    32'(bus.mem_be),    32'(m_be));
    chk("m_mem_addr",  32'(bus.mem_addr),  m_maddr);
    chk("m_mem_wdata", bus.mem_wdata,      m_wd);
    chk("m_if_rvalid", 32'(bus.if_rvalid), 32'(ev_if));
    chk("m_if_rdata",  bus.if_rdata,       e_ifd);
    chk("m_ld_rvalid", 32'(bus.ld_rvalid), 32'(ev_ld));
    chk("m_ld_rdata",  bus.ld_rdata,       e_ldd);
    chk("m_err_valid", 32'(bus.err_valid), 32'(ev_err));
    chk("m_err_addr",  bus.err_addr,       e_erra);
    // schedule next-cycle responses and memory effects
    if (m_win != W_NONE && !m_ok) err_exp_q.push_back(m_a);
    if (m_win == W_IF && m_ok) if_exp_q.push_back(model_mem[m_widx]);
    if (m_win == W_LD)
      ld_exp_q.push_back(m_ok ? ld_extract(bus.ld_op, model_mem[m_widx], m_off) : 32'h0);
    if (m_win == W_ST && m_ok) begin
      m_word = model_mem[m_widx];
      for (int k = 0; k < m_size; k++) m_word[(m_off + k) * 8 +: 8] = m_d[k * 8 +: 8];
      model_mem[m_widx] = m_word;
    end
    if (rst || !bus.if_req || m_win == W_IF) m_starve = 0;
    else if (m_starve < STARVE_MAX)          m_starve = m_starve + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 0;
    bus.ld_req = 0;
    bus.st_req = 0;
  endtask

  task automatic do_ld(input logic [2:0] op, input logic [31:0] a);
    bus.ld_req = 1; bus.ld_op = op; bus.ld_addr = a;
  endtask

  task automatic do_st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.st_req = 1; bus.st_op = op; bus.st_addr = a; bus.st_data = d;
  endtask

  task automatic do_if(input logic [31:0] a);
    bus.if_req = 1; bus.if_addr = a;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    bus.if_addr = 0; bus.ld_op = 0; bus.ld_addr = 0;
    bus.st_op = 0; bus.st_addr = 0; bus.st_data = 0;
    rst = 1;
    repeat (2) cyc();

    // reset: a pending fetch is not granted, everything quiet
    do_if(32'h0);
    #2;
    chk("rst_if_gnt", 32'(bus.if_gnt), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_starve", 32'(dbg_starve), 0);
    chk("rst_owner",  32'(dbg_owner),  32'(NONE));

    // first fetch after reset
    cyc(); rst = 0; #2;
    chk("if0_gnt",  32'(bus.if_gnt),   1);
    chk("if0_addr", 32'(bus.mem_addr), 0);
    cyc(); idle(); #2;
    chk("if0_rvalid", 32'(bus.if_rvalid), 1);
    chk("if0_rdata",  bus.if_rdata,       32'h00000013);

    // SB 0xA5 @0x102, then LB / LBU @0x102
    cyc(); do_st(OP_SB, 32'h102, 32'h000000A5); #2;
    chk("sb_gnt",   32'(bus.st_gnt),   1);
    chk("sb_be",    32'(bus.mem_be),   32'h4);
    chk("sb_wdata", bus.mem_wdata,     32'hA5A5A5A5);
    chk("sb_addr",  32'(bus.mem_addr), 32'h40);
    cyc(); idle(); do_ld(OP_LB, 32'h102); #2;
    chk("lb_gnt", 32'(bus.ld_gnt), 1);
    cyc(); do_ld(OP_LBU, 32'h102); #2;
    chk("lb_rdata", bus.ld_rdata, 32'hFFFFFFA5);
    cyc(); idle(); #2;
    chk("lbu_rdata", bus.ld_rdata, 32'h000000A5);

    // ld + st + if together: ld, then st, then if
    cyc(); do_ld(OP_LW, 32'h200); do_st(OP_SW, 32'h300, 32'h12345678); do_if(32'h10); #2;
    chk("tri1_ld", 32'(bus.ld_gnt), 1);
    chk("tri1_st", 32'(bus.st_gnt), 0);
    chk("tri1_if", 32'(bus.if_gnt), 0);
    cyc(); bus.ld_req = 0; #2;
    chk("tri2_st", 32'(bus.st_gnt), 1);
    chk("tri2_if", 32'(bus.if_gnt), 0);
    cyc(); bus.st_req = 0; #2;
    chk("tri3_starve", 32'(dbg_starve),  2);
    chk("tri3_if",     32'(bus.if_gnt),  1);
    cyc(); idle(); #2;

    // fetch starvation: forced grant after STARVE_MAX denials
    cyc(); do_ld(OP_LW, 32'h300); do_if(32'h14);
    for (int k = 1; k <= STARVE_MAX; k++) begin
      #2;
      chk($sformatf("starve_ld%0d", k), 32'(bus.ld_gnt), 1);
      cyc();
    end
    #2;
    chk("starve_if_gnt", 32'(bus.if_gnt), 1);
    chk("starve_ld_gnt", 32'(bus.ld_gnt), 0);
    cyc(); #2;
    chk("starve_ld_again", 32'(bus.ld_gnt), 1);
    chk("starve_cleared",  32'(dbg_starve), 0);
    cyc(); idle(); #2;
    chk("sw_readback", bus.ld_rdata, 32'h12345678);

    // misaligned LW @0x6
    cyc(); do_ld(OP_LW, 32'h6); #2;
    chk("mis_ld_gnt", 32'(bus.ld_gnt), 1);
    chk("mis_mem_en", 32'(bus.mem_en), 0);
    cyc(); idle(); #2;
    chk("mis_rvalid",   32'(bus.ld_rvalid), 1);
    chk("mis_rdata",    bus.ld_rdata,       0);
    chk("mis_err",      32'(bus.err_valid), 1);
    chk("mis_err_addr", bus.err_addr,       32'h6);

    // halfword store/load, illegal op, misaligned store, address wrap
    cyc(); do_st(OP_SH, 32'h22, 32'h0000BEEF); #2;
    chk("sh_be",    32'(bus.mem_be), 32'hC);
    chk("sh_wdata", bus.mem_wdata,   32'hBEEFBEEF);
    cyc(); idle(); do_ld(OP_LH, 32'h22); #2;
    cyc(); do_ld(OP_LHU, 32'h22); #2;
    chk("lh_rdata", bus.ld_rdata, 32'hFFFFBEEF);
    cyc(); do_ld(3'b011, 32'h40); #2;
    chk("lhu_rdata",  bus.ld_rdata,       32'h0000BEEF);
    chk("illop_en",   32'(bus.mem_en),    0);
    cyc(); idle(); do_st(OP_SH, 32'h21, 32'h00001234); #2;
    chk("illop_err",  bus.err_addr,       32'h40);
    chk("missh_gnt",  32'(bus.st_gnt),    1);
    chk("missh_we",   32'(bus.mem_we),    0);
    cyc(); idle(); do_ld(OP_LW, 32'h00010008); #2;
    chk("missh_err",  bus.err_addr,       32'h21);
    chk("wrap_addr",  32'(bus.mem_addr),  32'h2);
    cyc(); idle(); #2;
    chk("wrap_rdata", bus.ld_rdata,       32'h0204061B);

    // reset right after a load grant drops the response
    cyc(); do_ld(OP_LW, 32'h4); #2;
    chk("rstmid_gnt", 32'(bus.ld_gnt), 1);
    cyc(); idle(); rst = 1; #2;
    chk("rstmid_rvalid", 32'(bus.ld_rvalid), 0);
    cyc();
    cyc(); rst = 0; do_if(32'h8); #2;
    chk("post_rst_starve", 32'(dbg_starve),  0);
    chk("post_rst_if_gnt", 32'(bus.if_gnt),  1);
    cyc(); idle(); #2;
    chk("post_rst_rdata",  bus.if_rdata,     32'h0204061B);

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM (unified instruction/data memory) among three requesters: instruction fetch, load (EX/MEM stage), and store (ID/EX stage). Each cycle it grants at most one access, generates byte enables for sub-word stores, and routes the one-cycle-latency read data back to its owner with load extraction and sign extension. Fetch starvation is bounded by a counter, and misaligned accesses are reported. It sits between the CPU core's fetch/load/store ports and the memory macro, replacing the separate instruction and data memories.

## Interface
- ADDR_W, 14, word-address width of the SRAM (memory = 2^ADDR_W words)
- STARVE_MAX, 4, consecutive denied cycles of a pending fetch before fetch is forced to win (1..15)
- clk  in  1  the only clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid (cycle after grant)
- if_rdata  out  32  fetched word
- ld_req  in  1  load request
- ld_op  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_addr  in  32  load byte address
- ld_gnt  out  1  load accepted
- ld_rvalid  out  1  ld_rdata valid
- ld_rdata  out  32  extracted, extended load data
- st_req  in  1  store request
- st_op  in  3  000 SB, 001 SH, 010 SW
- st_addr  in  32  store byte address
- st_data  in  32  store data, right-aligned
- st_gnt  out  1  store accepted (write happens at this edge)
- err_valid  out  1  one-cycle pulse: misaligned or illegal-op access consumed
- err_addr  out  32  offending byte address
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write
- mem_be  out  4  byte enables (bit i = byte lane i)
- mem_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  SRAM read data, valid one cycle after mem_en & ~mem_we

## Operation
- Priority: ld > st > if. The load is older in program order than the store. Override: when starve_cnt == STARVE_MAX and if_req is high, fetch wins.
- starve_cnt (4 bit): increments when if_req & ~if_gnt, saturating at STARVE_MAX; clears on if_gnt or ~if_req.
- Grants are combinational from the requests and current state. At most one gnt per cycle. A requester that is not granted keeps its request; the block holds no request queue.
- Alignment rule: LH/LHU/SH need addr[0]==0; LW/SW/fetch need addr[1:0]==0. Undefined op codes are illegal. A granted misaligned or illegal access does not assert mem_en. It pulses err_valid and err_addr next cycle. A misaligned load also returns ld_rvalid with ld_rdata = 0.
- Stores: mem_be = 0001<<a for SB, 0011<<a for SH, 1111 for SW (a = addr[1:0]). mem_wdata replicates the byte or half across all lanes.
- Upper address bits above ADDR_W+1 are ignored (wrap).
- Response tracking register resp_owner ∈ {NONE, IF, LD}, plus latched ld_op and addr[1:0] for load extraction. It is set on a read grant and otherwise NONE.
- Load extract: the byte/half is selected by the latched offset. LB/LH sign-extend; LBU/LHU zero-extend.

## Timing
- Read latency: grant in cycle N, rvalid and rdata in N+1. Back-to-back grants every cycle give full throughput.
- Store: memory is written at the edge that ends the st_gnt cycle. A load granted the next cycle at the same address returns the new data.
- rvalid signals are single-cycle pulses. rdata is 0 when the matching rvalid is low.
- Reset values: all gnt, rvalid, err_valid, and mem_en/mem_we are 0; all data/address outputs are 0; starve_cnt = 0; resp_owner = NONE. While rst is high, no grants are issued.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rvalid. Its data is discarded.
- Simultaneous ld + st + if: ld is granted, st waits one cycle, if waits (starve_cnt++).

## Structure
- Package mem_arb_pkg: memory op encodings (LB..LHU, SB..SW), owner_t enum {NONE, IF, LD}, alignment-check function.
- Sub-module mem_lane_align: combinational store lane replication and byte enables, plus load extraction and extension. Everything else is in the arbiter.

## Test plan
- Reset then if_req @0x0 with mem preloaded 0x00000013 -> if_gnt in the same cycle, if_rvalid next cycle with if_rdata = 0x00000013; all outputs 0 during rst.
- SB 0xA5 @0x102, then LB @0x102 and LBU @0x102 -> mem_be=0100; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- ld, st, and if all asserted for 3 cycles -> grant order ld, st, if. Then continuous ld_req with if_req high -> if_gnt forced on the 5th denied cycle (STARVE_MAX=4).
- LW @0x0000_0006 -> ld_gnt, no mem_en, next cycle ld_rvalid with ld_rdata 0, err_valid with err_addr 0x6.
- ld_gnt in cycle N, rst high in N+1 -> no ld_rvalid. After reset release, starve_cnt = 0 and a fetch is granted immediately.
